// File: rtl/st_adapter_pkg.sv
// Shared types and helpers for the Avalon-ST channel adapters: FSM state
// encoding, channel-legality check and saturating increment.
package st_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Legal when no bit survives above the output width and the value fits CHAN_MAX.
  function automatic logic chan_legal(input logic [31:0] chan, input int out_w,
                                      input logic [31:0] chan_max);
    logic [31:0] hi;
    hi = (out_w >= 32) ? 32'd0 : (chan >> out_w);
    return (hi == 32'd0) && (chan <= chan_max);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Generic two-entry ready/valid register slice: an output register plus one
// skid entry; in_ready is registered and means "skid entry empty".
module st_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_bus,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_bus
);

  logic         r_in_ready;
  logic         r_out_valid;
  logic [W-1:0] r_out_bus;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_bus;
  logic         w_in_fire;
  logic         w_out_load;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_load = ~r_out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the payload registers are reset as well, so every output reads 0
      // in reset and no stale beat can reappear after release.
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_bus    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_bus   <= '0;
    end else if (w_out_load) begin
      if (r_skid_valid) begin
        r_out_bus    <= r_skid_bus;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) r_out_bus <= in_bus;
      end
      r_in_ready <= 1'b1;
    end else if (w_in_fire) begin
      // Output is stalled: park the beat and close the input.
      r_skid_bus   <= in_bus;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bus   = r_out_bus;

endmodule

// File: rtl/st_channel_adapter_pkt.sv
// Packet-aware Avalon-ST channel adapter: validates and locks the channel per
// packet, drops illegal or misframed packets, and keeps saturating counters.
module st_channel_adapter_pkt
  import st_adapter_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int IN_CHAN_W    = 1,
  parameter int OUT_CHAN_W   = 8,
  parameter int CHAN_MAX     = 255,
  parameter int PKT_LOCK     = 1,
  parameter int DROP_ILLEGAL = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic                  err_illegal,
  output logic                  err_proto,
  output logic [CNT_W-1:0]      pkt_count,
  output logic [CNT_W-1:0]      drop_count
);

  localparam int BUS_W = DATA_W + OUT_CHAN_W + 2;

  state_e                r_state;
  logic [OUT_CHAN_W-1:0] r_lock_chan;
  logic                  r_lock_legal;
  logic                  r_err_illegal;
  logic                  r_err_proto;
  logic [CNT_W-1:0]      r_pkt_count;
  logic [CNT_W-1:0]      r_drop_count;

  logic                  w_accept;
  logic                  w_legal;
  logic [OUT_CHAN_W-1:0] w_mapped;
  logic                  w_fwd;
  logic [OUT_CHAN_W-1:0] w_out_chan;
  state_e                w_state_nxt;
  logic                  w_err_illegal;
  logic                  w_err_proto;
  logic                  w_trunc;
  logic                  w_drop_eop;
  logic [CNT_W-1:0]      w_drop_nxt;
  logic [BUS_W-1:0]      w_out_bus;

  assign w_accept = in_valid & in_ready;
  assign w_legal  = chan_legal(32'(in_channel), OUT_CHAN_W, 32'(CHAN_MAX));
  assign w_mapped = OUT_CHAN_W'(in_channel);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    w_fwd         = 1'b0;
    w_out_chan    = '0;
    w_state_nxt   = r_state;
    w_err_illegal = 1'b0;
    w_err_proto   = 1'b0;
    w_trunc       = 1'b0;
    w_drop_eop    = 1'b0;
    if (w_accept) begin
      if (in_startofpacket) begin
        // A SOP inside an open packet closes it and restarts as from IDLE.
        if (r_state != ST_IDLE) begin
          w_err_proto = 1'b1;
          w_trunc     = (r_state == ST_FWD);
        end
        if (w_legal) begin
          w_fwd       = 1'b1;
          w_out_chan  = w_mapped;
          w_state_nxt = in_endofpacket ? ST_IDLE : ST_FWD;
        end else begin
          w_err_illegal = 1'b1;
          if (DROP_ILLEGAL != 0) begin
            w_state_nxt = in_endofpacket ? ST_IDLE : ST_DROP;
            w_drop_eop  = in_endofpacket;
          end else begin
            w_fwd       = 1'b1;
            w_state_nxt = in_endofpacket ? ST_IDLE : ST_FWD;
          end
        end
      end else begin
        unique case (r_state)
          ST_IDLE: w_err_proto = 1'b1;
          ST_FWD: begin
            w_fwd      = 1'b1;
            w_out_chan = (PKT_LOCK != 0) ? r_lock_chan : (r_lock_legal ? w_mapped : '0);
            if (in_endofpacket) w_state_nxt = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) begin
              w_state_nxt = ST_IDLE;
              w_drop_eop  = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // A truncated FWD packet and a single-beat illegal drop can land together.
  always_comb begin
    w_drop_nxt = r_drop_count;
    if (w_trunc)    w_drop_nxt = CNT_W'(sat_inc(32'(w_drop_nxt), CNT_W));
    if (w_drop_eop) w_drop_nxt = CNT_W'(sat_inc(32'(w_drop_nxt), CNT_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_lock_chan   <= '0;
      r_lock_legal  <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_proto   <= 1'b0;
      r_pkt_count   <= '0;
      r_drop_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_err_illegal <= w_err_illegal;
      r_err_proto   <= w_err_proto;
      r_drop_count  <= w_drop_nxt;
      if (w_accept && in_startofpacket) begin
        r_lock_chan  <= w_legal ? w_mapped : '0;
        r_lock_legal <= w_legal;
      end
      if (out_valid && out_ready && out_endofpacket)
        r_pkt_count <= CNT_W'(sat_inc(32'(r_pkt_count), CNT_W));
    end
  end

  st_skid_buffer #(.W(BUS_W)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w_fwd),
    .in_ready  (in_ready),
    .in_bus    ({in_data, w_out_chan, in_startofpacket, in_endofpacket}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (w_out_bus)
  );

  assign {out_data, out_channel, out_startofpacket, out_endofpacket} = w_out_bus;
  assign err_illegal = r_err_illegal;
  assign err_proto   = r_err_proto;
  assign pkt_count   = r_pkt_count;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_st_channel_adapter_pkt.sv
// Directed bench: DUT "a" uses default parameters, DUT "b" a narrow
// 4-bit-in / 2-bit-out channel map with CHAN_MAX=2.
module tb_st_channel_adapter_pkt;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_in_ready, a_in_valid, a_in_sop, a_in_eop, a_out_ready;
  logic [7:0] a_in_data;
  logic [0:0] a_in_channel;
  logic       a_out_valid, a_out_sop, a_out_eop, a_err_illegal, a_err_proto;
  logic [7:0] a_out_data, a_out_channel;
  logic [15:0] a_pkt_count, a_drop_count;

  logic       b_in_ready, b_in_valid, b_in_sop, b_in_eop, b_out_ready;
  logic [7:0] b_in_data;
  logic [3:0] b_in_channel;
  logic       b_out_valid, b_out_sop, b_out_eop, b_err_illegal, b_err_proto;
  logic [7:0] b_out_data;
  logic [1:0] b_out_channel;
  logic [15:0] b_pkt_count, b_drop_count;

  st_channel_adapter_pkt u_a (
    .clk(clk), .reset_n(reset_n), .in_ready(a_in_ready), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_channel(a_in_channel), .in_startofpacket(a_in_sop),
    .in_endofpacket(a_in_eop), .out_ready(a_out_ready), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_channel(a_out_channel), .out_startofpacket(a_out_sop),
    .out_endofpacket(a_out_eop), .err_illegal(a_err_illegal), .err_proto(a_err_proto),
    .pkt_count(a_pkt_count), .drop_count(a_drop_count)
  );

  st_channel_adapter_pkt #(.IN_CHAN_W(4), .OUT_CHAN_W(2), .CHAN_MAX(2), .DROP_ILLEGAL(1)) u_b (
    .clk(clk), .reset_n(reset_n), .in_ready(b_in_ready), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_channel(b_in_channel), .in_startofpacket(b_in_sop),
    .in_endofpacket(b_in_eop), .out_ready(b_out_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_channel(b_out_channel), .out_startofpacket(b_out_sop),
    .out_endofpacket(b_out_eop), .err_illegal(b_err_illegal), .err_proto(b_err_proto),
    .pkt_count(b_pkt_count), .drop_count(b_drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Output beats as {data[7:0], channel[7:0], sop, eop}, captured on handshake.
  logic [17:0] a_q[$];
  logic [17:0] b_q[$];
  int a_n_ill = 0, a_n_proto = 0, b_n_ill = 0, b_n_proto = 0;

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) a_q.push_back({a_out_data, a_out_channel, a_out_sop, a_out_eop});
    if (b_out_valid && b_out_ready) b_q.push_back({b_out_data, 6'd0, b_out_channel, b_out_sop, b_out_eop});
    if (a_err_illegal) a_n_ill++;
    if (a_err_proto)   a_n_proto++;
    if (b_err_illegal) b_n_ill++;
    if (b_err_proto)   b_n_proto++;
  end

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic send(input bit sel, input logic [7:0] d, input logic [3:0] ch,
                      input logic sop, input logic eop);
    bit acc = 1'b0;
    if (!sel) begin
      a_in_valid = 1'b1; a_in_data = d; a_in_channel = ch[0]; a_in_sop = sop; a_in_eop = eop;
    end else begin
      b_in_valid = 1'b1; b_in_data = d; b_in_channel = ch; b_in_sop = sop; b_in_eop = eop;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = sel ? b_in_ready : a_in_ready;
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout dut=%0d data=%h: in_ready never seen", sel, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_data, a_out_channel, a_out_sop, a_out_eop,
         a_err_illegal, a_err_proto, a_pkt_count, a_drop_count} !== '0) begin
      errors++; $display("FAIL reset_outputs_a: got nonzero output in reset, want all 0");
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_pkt_count, b_drop_count} !== '0) begin
      errors++; $display("FAIL reset_outputs_b: got nonzero output in reset, want all 0");
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_rise: a=%b b=%b want 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_basic;
    logic [17:0] exp;
    a_q.delete();
    send(0, 8'h11, 4'd1, 1'b1, 1'b0);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'h11) begin
      errors++; $display("FAIL basic_latency: valid=%b data=%h want 1 11", a_out_valid, a_out_data);
    end
    send(0, 8'h12, 4'd1, 1'b0, 1'b0);
    send(0, 8'h13, 4'd1, 1'b0, 1'b0);
    send(0, 8'h14, 4'd1, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (a_q.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d beats want 4", a_q.size());
    end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      exp = {8'h11 + 8'(i), 8'd1, i == 0, i == 3};
      checks++;
      if (a_q[i] !== exp) begin
        errors++; $display("FAIL basic_beat%0d: got %h want %h", i, a_q[i], exp);
      end
    end
    checks++;
    if (a_pkt_count !== 16'd1) begin
      errors++; $display("FAIL basic_pkt_count: got %0d want 1", a_pkt_count);
    end
  endtask

  task automatic test_stall;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [17:0] exp;
    a_q.delete();
    fork
      begin
        send(0, 8'h11, 4'd1, 1'b1, 1'b0);
        send(0, 8'h12, 4'd1, 1'b0, 1'b0);
        send(0, 8'h13, 4'd1, 1'b0, 1'b0);
        send(0, 8'h14, 4'd1, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          a_out_ready = pat[i][0];
          @(posedge clk);
          #1;
        end
        a_out_ready = 1'b1;
      end
      begin
        logic [17:0] prev, cur;
        bit prev_stall, prev_acc;
        prev = '0; prev_stall = 1'b0; prev_acc = 1'b0;
        for (int i = 0; i < 14; i++) begin
          @(negedge clk);
          cur = {a_out_data, a_out_channel, a_out_sop, a_out_eop};
          if (prev_stall) begin
            checks++;
            if (cur !== prev || a_out_valid !== 1'b1) begin
              errors++; $display("FAIL stall_stable: got %h/%b want %h/1", cur, a_out_valid, prev);
            end
          end
          if (prev_stall && prev_acc) begin
            checks++;
            if (a_in_ready !== 1'b0) begin
              errors++; $display("FAIL stall_in_ready: got %b want 0", a_in_ready);
            end
          end
          prev = cur;
          prev_stall = a_out_valid && !a_out_ready;
          prev_acc = a_in_valid && a_in_ready;
        end
      end
    join
    idle(2);
    checks++;
    if (a_q.size() != 4) begin
      errors++; $display("FAIL stall_count: got %0d beats want 4", a_q.size());
    end
    for (int i = 0; i < 4 && i < a_q.size(); i++) begin
      exp = {8'h11 + 8'(i), 8'd1, i == 0, i == 3};
      checks++;
      if (a_q[i] !== exp) begin
        errors++; $display("FAIL stall_beat%0d: got %h want %h", i, a_q[i], exp);
      end
    end
    checks++;
    if (a_pkt_count !== 16'd2) begin
      errors++; $display("FAIL stall_pkt_count: got %0d want 2", a_pkt_count);
    end
  endtask

  task automatic test_illegal_drop;
    logic [17:0] exp;
    b_q.delete();
    b_n_ill = 0;
    send(1, 8'h31, 4'd3, 1'b1, 1'b0);
    send(1, 8'h32, 4'd3, 1'b0, 1'b1);
    send(1, 8'h51, 4'd5, 1'b1, 1'b0);
    send(1, 8'h52, 4'd5, 1'b0, 1'b1);
    send(1, 8'h21, 4'd2, 1'b1, 1'b0);
    send(1, 8'h22, 4'd2, 1'b0, 1'b0);
    send(1, 8'h23, 4'd2, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (b_n_ill != 2) begin
      errors++; $display("FAIL illegal_pulses: got %0d want 2", b_n_ill);
    end
    checks++;
    if (b_drop_count !== 16'd2) begin
      errors++; $display("FAIL illegal_drop_count: got %0d want 2", b_drop_count);
    end
    checks++;
    if (b_q.size() != 3) begin
      errors++; $display("FAIL illegal_fwd_count: got %0d beats want 3", b_q.size());
    end
    for (int i = 0; i < 3 && i < b_q.size(); i++) begin
      exp = {8'h21 + 8'(i), 8'd2, i == 0, i == 2};
      checks++;
      if (b_q[i] !== exp) begin
        errors++; $display("FAIL illegal_fwd_beat%0d: got %h want %h", i, b_q[i], exp);
      end
    end
    checks++;
    if (b_pkt_count !== 16'd1) begin
      errors++; $display("FAIL illegal_pkt_count: got %0d want 1", b_pkt_count);
    end
    send(1, 8'h33, 4'd3, 1'b1, 1'b1);
    checks++;
    if (b_drop_count !== 16'd3 || b_err_illegal !== 1'b1) begin
      errors++; $display("FAIL single_beat_drop: drop=%0d err=%b want 3 1", b_drop_count, b_err_illegal);
    end
    idle(2);
    checks++;
    if (b_q.size() != 3) begin
      errors++; $display("FAIL single_beat_leak: got %0d beats want 3", b_q.size());
    end
  endtask

  task automatic test_lock;
    logic [17:0] exp;
    a_q.delete();
    send(0, 8'h41, 4'd1, 1'b1, 1'b0);
    send(0, 8'h42, 4'd0, 1'b0, 1'b0);
    send(0, 8'h43, 4'd0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (a_q.size() != 3) begin
      errors++; $display("FAIL lock_count: got %0d beats want 3", a_q.size());
    end
    for (int i = 0; i < 3 && i < a_q.size(); i++) begin
      exp = {8'h41 + 8'(i), 8'd1, i == 0, i == 2};
      checks++;
      if (a_q[i] !== exp) begin
        errors++; $display("FAIL lock_beat%0d: got %h want %h", i, a_q[i], exp);
      end
    end
  endtask

  task automatic test_proto;
    logic [17:0] exp_q[3];
    exp_q[0] = {8'h51, 8'd0, 1'b1, 1'b0};
    exp_q[1] = {8'h52, 8'd1, 1'b1, 1'b0};
    exp_q[2] = {8'h53, 8'd1, 1'b0, 1'b1};
    a_q.delete();
    a_n_proto = 0;
    send(0, 8'h50, 4'd0, 1'b0, 1'b0);
    send(0, 8'h51, 4'd0, 1'b1, 1'b0);
    send(0, 8'h52, 4'd1, 1'b1, 1'b0);
    send(0, 8'h53, 4'd0, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (a_n_proto != 2) begin
      errors++; $display("FAIL proto_pulses: got %0d want 2", a_n_proto);
    end
    checks++;
    if (a_drop_count !== 16'd1) begin
      errors++; $display("FAIL proto_drop_count: got %0d want 1", a_drop_count);
    end
    checks++;
    if (a_q.size() != 3) begin
      errors++; $display("FAIL proto_count: got %0d beats want 3", a_q.size());
    end
    for (int i = 0; i < 3 && i < a_q.size(); i++) begin
      checks++;
      if (a_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL proto_beat%0d: got %h want %h", i, a_q[i], exp_q[i]);
      end
    end
    checks++;
    if (a_pkt_count !== 16'd4) begin
      errors++; $display("FAIL proto_pkt_count: got %0d want 4", a_pkt_count);
    end
  endtask

  task automatic test_reset_mid_packet;
    a_out_ready = 1'b0;
    send(0, 8'h61, 4'd1, 1'b1, 1'b0);
    send(0, 8'h62, 4'd1, 1'b0, 1'b0);
    checks++;
    if (a_in_ready !== 1'b0 || a_out_data !== 8'h61) begin
      errors++; $display("FAIL midrst_skid_full: ready=%b data=%h want 0 61", a_in_ready, a_out_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_data, a_out_channel, a_out_sop,
         a_pkt_count, a_drop_count} !== '0) begin
      errors++; $display("FAIL midrst_outputs: valid=%b data=%h pkt=%0d drop=%0d want all 0",
                         a_out_valid, a_out_data, a_pkt_count, a_drop_count);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    a_out_ready = 1'b1;
    a_q.delete();
    @(posedge clk);
    #1;
    send(0, 8'h71, 4'd1, 1'b1, 1'b0);
    send(0, 8'h72, 4'd1, 1'b0, 1'b1);
    idle(3);
    checks++;
    if (a_q.size() != 2) begin
      errors++; $display("FAIL midrst_count: got %0d beats want 2", a_q.size());
    end else begin
      checks++;
      if (a_q[0] !== {8'h71, 8'd1, 1'b1, 1'b0} || a_q[1] !== {8'h72, 8'd1, 1'b0, 1'b1}) begin
        errors++; $display("FAIL midrst_beats: got %h %h want 71010 / 72011 pattern", a_q[0], a_q[1]);
      end
    end
    checks++;
    if (a_pkt_count !== 16'd1) begin
      errors++; $display("FAIL midrst_pkt_count: got %0d want 1", a_pkt_count);
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_data = '0; a_in_channel = '0; a_in_sop = 1'b0; a_in_eop = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_channel = '0; b_in_sop = 1'b0; b_in_eop = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_illegal_drop();
    test_lock();
    test_proto();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
